// File: rtl/divider_pkg.sv
// Shared types and helpers for the radix-2^STEP restoring divider.
// Holds the FSM state encoding, iteration-count helper and a conditional two's-complement negate.
package divider_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Number of CALC cycles for a given width and quotient bits per cycle.
    function automatic int iters(input int width, input int step);
        return width / step;
    endfunction

    // Serves both abs() at operand capture and the sign fix-up on the result; callers truncate.
    function automatic logic [63:0] neg_if(input logic [63:0] v, input logic en);
        return en ? (~v + 64'd1) : v;
    endfunction

endpackage

// File: rtl/divider_radix_step.sv
// Combinational restoring stage: retires STEP quotient bits from one partial remainder.
// Partial remainder stays below the divisor, so the WIDTH+1 bit difference MSB is the borrow.
module divider_radix_step #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [STEP-1:0]  i_bits,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [STEP-1:0]  o_qbits
);

    logic [WIDTH-1:0] r;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    always_comb begin
        r       = i_rem;
        shifted = '0;
        diff    = '0;
        o_qbits = '0;
        for (int i = STEP - 1; i >= 0; i--) begin
            shifted    = {r, i_bits[i]};
            diff       = shifted - {1'b0, i_divisor};
            o_qbits[i] = ~diff[WIDTH];
            r          = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        end
        o_rem = r;
    end

endmodule

// File: rtl/divider_radix.sv
// Multi-cycle restoring divider, STEP quotient bits per cycle; o_valid rises N=WIDTH/STEP edges after the accept edge and holds until i_ready.
// Signed operation is only built when DIVIDER_RADIX_SIGNED_EN is defined; i_cg low freezes all state.
module divider_radix
    import divider_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cg,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_signed,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_divByZero,
    output logic             o_busy
);

    localparam int N  = iters(WIDTH, STEP);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic [WIDTH-1:0]   dvnd_q, dvnd_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               valid_q, valid_d;
    logic               dbz_q, dbz_d;

    logic               accept;
    logic [WIDTH-1:0]   step_rem;
    logic [STEP-1:0]    step_qbits;
    logic [WIDTH-1:0]   quo_raw, quo_fix, rem_fix;
    logic [WIDTH-1:0]   opa_abs, opb_abs;

    assign o_ready = i_cg && ((state_q == S_IDLE) || ((state_q == S_DONE) && i_ready));
    assign accept  = i_valid && o_ready;

    // Upper half of the working register is the partial remainder, lower half shifts dividend out and quotient in.
    divider_radix_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .i_rem     (work_q[2*WIDTH-1:WIDTH]),
        .i_bits    (work_q[WIDTH-1 -: STEP]),
        .i_divisor (dvsr_q),
        .o_rem     (step_rem),
        .o_qbits   (step_qbits)
    );

    assign quo_raw = (work_q[WIDTH-1:0] << STEP) | WIDTH'(step_qbits);

`ifdef DIVIDER_RADIX_SIGNED_EN
    logic op_neg_a, op_neg_b;
    logic neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

    assign op_neg_a  = i_signed && i_dividend[WIDTH-1];
    assign op_neg_b  = i_signed && i_divisor[WIDTH-1];
    assign opa_abs   = WIDTH'(neg_if(64'(i_dividend), op_neg_a));
    assign opb_abs   = WIDTH'(neg_if(64'(i_divisor), op_neg_b));
    assign neg_quo_d = accept ? (op_neg_a ^ op_neg_b) : neg_quo_q;
    assign neg_rem_d = accept ? op_neg_a : neg_rem_q;
    // Most-negative / -1 needs no special case: |q| = 2^(WIDTH-1) negates to itself, remainder is 0.
    assign quo_fix   = WIDTH'(neg_if(64'(quo_raw), neg_quo_q));
    assign rem_fix   = WIDTH'(neg_if(64'(step_rem), neg_rem_q));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (i_cg) begin
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end
`else
    logic unused_signed;

    assign unused_signed = i_signed;
    assign opa_abs       = i_dividend;
    assign opb_abs       = i_divisor;
    assign quo_fix       = quo_raw;
    assign rem_fix       = step_rem;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        dvsr_d  = dvsr_q;
        dvnd_d  = dvnd_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        valid_d = valid_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE: ;
            S_CALC: begin
                work_d = {step_rem, quo_raw};
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    dbz_d   = (dvsr_q == '0);
                    quo_d   = (dvsr_q == '0) ? '1 : quo_fix;
                    rem_d   = (dvsr_q == '0) ? dvnd_q : rem_fix;
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            state_d = S_CALC;
            cnt_d   = CNT_LAST;
            work_d  = {{WIDTH{1'b0}}, opa_abs};
            dvsr_d  = opb_abs;
            dvnd_d  = i_dividend;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            dvsr_q  <= '0;
            dvnd_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            dbz_q   <= 1'b0;
        end else if (i_cg) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            dvsr_q  <= dvsr_d;
            dvnd_q  <= dvnd_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            dbz_q   <= dbz_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_quotient  = quo_q;
    assign o_remainder = rem_q;
    assign o_divByZero = dbz_q;
    assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_divider_radix.sv
// Bench for divider_radix: three instances (STEP 1, 2, 4) checked against an arithmetic reference model.
// Covers reset, directed corner cases, backpressure, back-to-back accept, mid-calc reset and randomized clock gating.
module tb_divider_radix;

    localparam int W  = 8;
    localparam int ND = 3;
`ifdef DIVIDER_RADIX_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [ND-1:0] cg, vld_in, rdy_out, vld_out, rdy_in, sgn, busy, dbz;
    logic [W-1:0]  dvnd [ND];
    logic [W-1:0]  dvsr [ND];
    logic [W-1:0]  quo  [ND];
    logic [W-1:0]  rem  [ND];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        divider_radix #(
            .WIDTH (W),
            .STEP  (1 << g)
        ) u_dut (
            .i_clk       (clk),
            .i_rst       (rst),
            .i_cg        (cg[g]),
            .i_valid     (vld_in[g]),
            .o_ready     (rdy_out[g]),
            .i_dividend  (dvnd[g]),
            .i_divisor   (dvsr[g]),
            .i_signed    (sgn[g]),
            .o_valid     (vld_out[g]),
            .i_ready     (rdy_in[g]),
            .o_quotient  (quo[g]),
            .o_remainder (rem[g]),
            .o_divByZero (dbz[g]),
            .o_busy      (busy[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int n_of(input int d);
        return W >> d;
    endfunction

    // Reference: {divByZero, quotient, remainder} from plain integer division.
    function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b, input logic s_eff);
        int sa, sb;
        logic [7:0] q, r;
        if (b == 8'd0) return {1'b1, 8'hFF, a};
        if (s_eff) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            if (sa == -128 && sb == -1) return {1'b0, a, 8'h00};
            q = 8'(sa / sb);
            r = 8'(sa % sb);
            return {1'b0, q, r};
        end
        q = a / b;
        r = a % b;
        return {1'b0, q, r};
    endfunction

    task automatic wait_result(input int d, input bit cg_rand, output int lat);
        int waited;
        waited = 0;
        lat    = 1;
        while (!vld_out[d] && waited < 400) begin
            if (cg_rand) cg[d] = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            if (cg[d]) lat++;
            #1;
            waited++;
        end
        cg[d] = 1'b1;
        check($sformatf("timeout%0d", d), 32'(vld_out[d]), 1);
    endtask

    task automatic check_res(input int d, input string tag, input logic [16:0] exp);
        check($sformatf("%s_q%0d", tag, d), 32'(quo[d]), 32'(exp[15:8]));
        check($sformatf("%s_r%0d", tag, d), 32'(rem[d]), 32'(exp[7:0]));
        check($sformatf("%s_dbz%0d", tag, d), 32'(dbz[d]), 32'(exp[16]));
    endtask

    task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b, input logic s,
                          input bit cg_rand, input int hold);
        logic [16:0] exp;
        int lat;
        exp       = model(a, b, s && SIGNED_BUILD);
        dvnd[d]   = a;
        dvsr[d]   = b;
        sgn[d]    = s;
        vld_in[d] = 1'b1;
        cg[d]     = 1'b1;
        #1;
        check($sformatf("rdy_idle%0d", d), 32'(rdy_out[d]), 1);
        @(posedge clk);
        #1;
        vld_in[d] = 1'b0;
        dvnd[d]   = 8'($urandom);
        dvsr[d]   = 8'($urandom);
        sgn[d]    = ~s;
        wait_result(d, cg_rand, lat);
        check($sformatf("lat%0d", d), 32'(lat), 32'(n_of(d) + 1));
        check_res(d, "op", exp);
        rdy_in[d] = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold_vld%0d", d), 32'(vld_out[d]), 1);
            check($sformatf("hold_rdy%0d", d), 32'(rdy_out[d]), 0);
            check_res(d, "hold", exp);
        end
        rdy_in[d] = 1'b1;
        @(posedge clk);
        #1;
        rdy_in[d] = 1'b0;
        check($sformatf("drain_vld%0d", d), 32'(vld_out[d]), 0);
        check($sformatf("drain_busy%0d", d), 32'(busy[d]), 0);
    endtask

    task automatic back_to_back(input int d);
        logic [16:0] exp1, exp2;
        int lat;
        exp1      = model(8'd100, 8'd7, 1'b0);
        exp2      = model(8'd251, 8'd10, 1'b0);
        dvnd[d]   = 8'd100;
        dvsr[d]   = 8'd7;
        sgn[d]    = 1'b0;
        vld_in[d] = 1'b1;
        @(posedge clk);
        #1;
        vld_in[d] = 1'b0;
        wait_result(d, 1'b0, lat);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_rdy%0d", d), 32'(rdy_out[d]), 0);
            check($sformatf("bp_vld%0d", d), 32'(vld_out[d]), 1);
            check_res(d, "bp", exp1);
            @(posedge clk);
            #1;
        end
        dvnd[d]   = 8'd251;
        dvsr[d]   = 8'd10;
        vld_in[d] = 1'b1;
        rdy_in[d] = 1'b1;
        #1;
        check($sformatf("b2b_rdy%0d", d), 32'(rdy_out[d]), 1);
        @(posedge clk);
        #1;
        vld_in[d] = 1'b0;
        rdy_in[d] = 1'b0;
        check($sformatf("b2b_vld%0d", d), 32'(vld_out[d]), 0);
        check($sformatf("b2b_busy%0d", d), 32'(busy[d]), 1);
        wait_result(d, 1'b0, lat);
        check($sformatf("b2b_lat%0d", d), 32'(lat), 32'(n_of(d) + 1));
        check_res(d, "b2b", exp2);
        rdy_in[d] = 1'b1;
        @(posedge clk);
        #1;
        rdy_in[d] = 1'b0;
    endtask

    task automatic mid_reset(input int d);
        dvnd[d]   = 8'd250;
        dvsr[d]   = 8'd3;
        sgn[d]    = 1'b0;
        vld_in[d] = 1'b1;
        @(posedge clk);
        #1;
        vld_in[d] = 1'b0;
        @(posedge clk);
        #1;
        check($sformatf("pre_rst_busy%0d", d), 32'(busy[d]), 1);
        rst = 1'b1;
        #1;
        check($sformatf("rst_vld%0d", d), 32'(vld_out[d]), 0);
        check($sformatf("rst_busy%0d", d), 32'(busy[d]), 0);
        check($sformatf("rst_q%0d", d), 32'(quo[d]), 0);
        check($sformatf("rst_r%0d", d), 32'(rem[d]), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_op(d, 8'd200, 8'd9, 1'b0, 1'b0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] a, b;
        rst    = 1'b1;
        cg     = '1;
        vld_in = '0;
        rdy_in = '0;
        sgn    = '0;
        for (int d = 0; d < ND; d++) begin
            dvnd[d] = '0;
            dvsr[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("init_vld%0d", d), 32'(vld_out[d]), 0);
            check($sformatf("init_busy%0d", d), 32'(busy[d]), 0);
            check($sformatf("init_rdy%0d", d), 32'(rdy_out[d]), 1);
            check_res(d, "init", 17'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int d = 0; d < ND; d++) begin
            run_op(d, 8'd100, 8'd7, 1'b0, 1'b0, 0);
            run_op(d, 8'hF9, 8'h02, 1'b1, 1'b0, 0);
            run_op(d, 8'hF9, 8'h02, 1'b0, 1'b0, 0);
            run_op(d, 8'h55, 8'h00, 1'b0, 1'b0, 1);
            run_op(d, 8'h55, 8'h00, 1'b1, 1'b0, 0);
            run_op(d, 8'h80, 8'hFF, 1'b1, 1'b0, 0);
            back_to_back(d);
            mid_reset(d);
        end

        for (int n = 0; n < 40; n++) begin
            for (int d = 0; d < ND; d++) begin
                a = 8'($urandom);
                case ($urandom_range(0, 7))
                    0:       b = 8'h00;
                    1, 2:    b = 8'($urandom_range(1, 15));
                    default: b = 8'($urandom);
                endcase
                if ($urandom_range(0, 15) == 0) begin
                    a = 8'h80;
                    b = 8'hFF;
                end
                run_op(d, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 3));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
